// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and widths for the ALU scheduler.
//   state_e        : scheduler FSM states (idle, waiting on ALU, response held)
//   OP_W / DATA_W  : opcode and operand/result widths of the shared ALU
//   SREG_W         : width of the ALU status register
//   MAX_OP_DEFAULT : highest opcode the ALU implements
package alu_sched_pkg;

    localparam int OP_W           = 4;
    localparam int DATA_W         = 8;
    localparam int SREG_W         = 4;
    localparam int MAX_OP_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way arbiter producing a one-hot grant.
//   clk, reset : clock and asynchronous active-high reset
//   req[1:0]   : request vector (bit N = requester N)
//   accept     : strobe, high when the current grant is taken this cycle
//   grant[1:0] : one-hot grant, all zero when no request
// Build option: ALU_SCHED_FIXED_PRIO_EN selects fixed priority (requester 0
// wins ties, no pointer); otherwise round-robin with a one-bit pointer that
// starts on requester 0 and moves to the other requester after every accept.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ALU_SCHED_FIXED_PRIO_EN

    // Clock, reset and accept only matter for the pointer, absent here.
    logic unused_inputs;
    assign unused_inputs = clk ^ reset ^ accept;

    always_comb begin
        // NOTE: default assignment first so every path drives grant; no latch is inferred.
        grant = 2'b00;
        if (req[0])      grant = 2'b01;
        else if (req[1]) grant = 2'b10;
    end

`else

    // ptr = 0: requester 0 preferred on a tie; ptr = 1: requester 1 preferred.
    logic ptr;

    always_comb begin
        // NOTE: default assignment first so every path drives grant; no latch is inferred.
        grant = 2'b00;
        if (req[0] && (!req[1] || !ptr)) grant = 2'b01;
        else if (req[1])                 grant = 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignment for sequential state avoids read/write races between flops.
            ptr <= grant[0];   // granted 0 -> prefer 1 next, and vice versa
        end
    end

`endif

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one clocked 8-bit ALU between two requesters.
// Accepts one operation at a time, drives the ALU input registers, waits
// ALU_LATENCY edges, captures result and status, and holds the response
// until it is consumed. Opcodes above MAX_OP are answered with an error
// response without touching the ALU.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b      : requester N handshake and operation (N = 0, 1)
//   resp_valid/ready             : response handshake
//   resp_id/result/sreg/err      : owning requester, ALU result, status, bad-opcode flag
//   alu_fsel/alu_a/alu_b         : registered ALU inputs
//   alu_out/alu_sreg             : ALU outputs
// Build option: ALU_SCHED_FIXED_PRIO_EN (see rr_arbiter2) makes requester 0
// win every tie instead of round-robin.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int MAX_OP      = MAX_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic [SREG_W-1:0] resp_sreg,
    output logic              resp_err,
    output logic [OP_W-1:0]   alu_fsel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [SREG_W-1:0] alu_sreg
);

    localparam int              CNT_W    = $clog2(ALU_LATENCY + 1);
    localparam logic [OP_W-1:0] MAX_OP_V = OP_W'(MAX_OP);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         req;
    logic [1:0]         grant;
    logic               accept;
    logic               sel;
    logic [OP_W-1:0]    sel_op;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

    // Requests are only visible to the arbiter in IDLE, so grant (and hence
    // ready) is zero whenever an operation is in flight. Masking with reset
    // keeps ready low while reset is asserted.
    assign req    = {req1_valid, req0_valid} & {2{(state == ST_IDLE) && !reset}};
    assign accept = |grant;
    assign sel    = grant[1];

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign resp_valid = (state == ST_RESP);

    assign sel_op = sel ? req1_op : req0_op;
    assign sel_a  = sel ? req1_a  : req0_a;
    assign sel_b  = sel ? req1_b  : req0_b;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_sreg   <= '0;
            resp_err    <= 1'b0;
            alu_fsel    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        resp_id <= sel;
                        if (sel_op <= MAX_OP_V) begin
                            alu_fsel <= sel_op;
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            cnt      <= CNT_W'(ALU_LATENCY);
                            state    <= ST_WAIT;
                        end else begin
                            // Unsupported opcode: answer at once, ALU inputs keep old values.
                            resp_err    <= 1'b1;
                            resp_result <= '0;
                            resp_sreg   <= '0;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // cnt == 1 marks the edge at which alu_out reflects the issued inputs.
                    if (cnt == CNT_W'(1)) begin
                        resp_result <= alu_out;
                        resp_sreg   <= alu_sreg;
                        resp_err    <= 1'b0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: randomized scoreboard bench for alu_scheduler.
// A stub ALU (op1 = A+B, op2 = A-B, otherwise A^B) sits behind the DUT.
// The driver predicts grants from a round-robin (or fixed-priority) model,
// checks ready outputs, and queues the expected response of each accepted
// operation; an independent monitor pops and compares whenever resp_valid
// is seen. A second DUT with ALU_LATENCY = 3 covers reset mid-operation.
module tb_alu_scheduler;
    import alu_sched_pkg::*;

    localparam int LAT   = 1;
    localparam int LAT3  = 3;
    localparam int MAXOP = 8;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic [3:0] sreg;
        logic       err;
        logic [3:0] fsel;
        logic [7:0] a;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT signals
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       resp_valid, resp_ready, resp_id, resp_err;
    logic [7:0] resp_result;
    logic [3:0] resp_sreg;
    logic [3:0] alu_fsel;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sreg;

    // latency-3 DUT signals
    logic       reset3;
    logic       q0_valid, q0_ready, q1_valid, q1_ready;
    logic [3:0] q0_op;
    logic [7:0] q0_a, q0_b;
    logic       r3_valid, r3_ready, r3_id, r3_err;
    logic [7:0] r3_result;
    logic [3:0] r3_sreg;
    logic [3:0] a3_fsel;
    logic [7:0] a3_a, a3_b, a3_out;
    logic [3:0] a3_sreg;
    logic [11:0] p3_0, p3_1;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cycle  = 0;
    bit   busy   = 1'b0;
    bit   model_ptr = 1'b0;
    logic [3:0] last_fsel = '0;
    logic [7:0] last_a = '0, last_b = '0;
    exp_t sb[$];

    alu_scheduler #(.ALU_LATENCY(LAT), .MAX_OP(MAXOP)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_sreg(resp_sreg), .resp_err(resp_err),
        .alu_fsel(alu_fsel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_sreg(alu_sreg)
    );

    alu_scheduler #(.ALU_LATENCY(LAT3), .MAX_OP(MAXOP)) dut3 (
        .clk(clk), .reset(reset3),
        .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_op(q0_op),
        .req0_a(q0_a), .req0_b(q0_b),
        .req1_valid(q1_valid), .req1_ready(q1_ready), .req1_op(4'd1),
        .req1_a(8'd0), .req1_b(8'd0),
        .resp_valid(r3_valid), .resp_ready(r3_ready), .resp_id(r3_id),
        .resp_result(r3_result), .resp_sreg(r3_sreg), .resp_err(r3_err),
        .alu_fsel(a3_fsel), .alu_a(a3_a), .alu_b(a3_b),
        .alu_out(a3_out), .alu_sreg(a3_sreg)
    );

    // Stub ALU function: returns {sreg, result}.
    function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        if (op == 4'd1)      r = a + b;
        else if (op == 4'd2) r = a - b;
        else                 r = a ^ b;
        return {(r == 8'd0), r[7], a[0], b[0], r};
    endfunction

    // Latency 1: combinational from the registered inputs.
    assign {alu_sreg, alu_out} = alu_ref(alu_fsel, alu_a, alu_b);

    // Latency 3: two extra register stages behind the registered inputs.
    always @(posedge clk) begin
        p3_0 <= alu_ref(a3_fsel, a3_a, a3_b);
        p3_1 <= p3_0;
    end
    assign {a3_sreg, a3_out} = p3_1;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // One stimulus cycle on the main DUT: apply inputs, check readies against
    // the arbitration model, and queue the expected response on acceptance.
    task automatic drive(input logic v0, input logic [3:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [3:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic rr);
        logic [1:0]  g;
        logic [3:0]  op;
        logic [7:0]  a, b;
        logic [11:0] f;
        exp_t        e;
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        resp_ready = rr;
        #1;
        g = 2'b00;
        if (!busy) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
            if (v0)      g = 2'b01;
            else if (v1) g = 2'b10;
`else
            if (v0 && v1) g = model_ptr ? 2'b10 : 2'b01;
            else if (v0)  g = 2'b01;
            else if (v1)  g = 2'b10;
`endif
        end
        check("req0_ready", req0_ready, g[0]);
        check("req1_ready", req1_ready, g[1]);
        if (g != 2'b00) begin
            e.id = g[1];
            op = g[1] ? o1 : o0;
            a  = g[1] ? a1 : a0;
            b  = g[1] ? b1 : b0;
            if (op > MAXOP) begin
                e.err = 1'b1; e.res = 8'd0; e.sreg = 4'd0;
                e.cyc = cycle + 1;
            end else begin
                f = alu_ref(op, a, b);
                e.err = 1'b0; e.res = f[7:0]; e.sreg = f[11:8];
                last_fsel = op; last_a = a; last_b = b;
                e.cyc = cycle + 1 + LAT;
            end
            e.fsel = last_fsel; e.a = last_a; e.b = last_b;
            sb.push_back(e);
            busy = 1'b1;
            model_ptr = !e.id;
        end
    endtask

    // Monitor: compares every presented response against the queue head.
    initial begin : monitor
        exp_t cur;
        bit   have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && resp_valid) begin
                if (!have) begin
                    check("resp_expected", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                        check("resp_latency", cycle, cur.cyc);
                        check("alu_fsel", alu_fsel, cur.fsel);
                        check("alu_a", alu_a, cur.a);
                        check("alu_b", alu_b, cur.b);
                    end
                end
                if (have) begin
                    check("resp_id", resp_id, cur.id);
                    check("resp_result", resp_result, cur.res);
                    check("resp_sreg", resp_sreg, cur.sreg);
                    check("resp_err", resp_err, cur.err);
                end
                if (resp_ready) begin
                    have = 1'b0;
                    busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0] o0, o1;
        int         k;
        reset = 1'b1; reset3 = 1'b1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        resp_ready = 0;
        q0_valid = 0; q0_op = 0; q0_a = 0; q0_b = 0; q1_valid = 0; r3_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_result", resp_result, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_alu_fsel", alu_fsel, 0);
        check("rst_alu_a", alu_a, 0);
        reset = 1'b0; reset3 = 1'b0;

        // Single request: 6 + 9 on requester 0.
        drive(1, 4'd1, 8'd6, 8'd9, 0, 4'd0, 8'd0, 8'd0, 1);
        repeat (3) drive(0, 4'd0, 8'd0, 8'd0, 0, 4'd0, 8'd0, 8'd0, 1);
        // Bad opcode on requester 1 (also moves the pointer back to 0).
        drive(0, 4'd0, 8'd0, 8'd0, 1, 4'd12, 8'd55, 8'd66, 1);
        repeat (3) drive(0, 4'd0, 8'd0, 8'd0, 0, 4'd0, 8'd0, 8'd0, 1);
        // Simultaneous requests: id0 (127-125) then id1 (3+6).
        drive(1, 4'd2, 8'd127, 8'd125, 1, 4'd1, 8'd3, 8'd6, 1);
        repeat (4) drive(0, 4'd0, 8'd0, 8'd0, 1, 4'd1, 8'd3, 8'd6, 1);
        // Both held valid: alternates under round-robin, only req0 under fixed priority.
        repeat (10) drive(1, 4'd1, 8'd20, 8'd30, 1, 4'd2, 8'd40, 8'd50, 1);
        repeat (3) drive(0, 4'd0, 8'd0, 8'd0, 0, 4'd0, 8'd0, 8'd0, 1);
        // Response stall: five cycles with resp_ready low, then release.
        drive(1, 4'd1, 8'd10, 8'd20, 0, 4'd0, 8'd0, 8'd0, 0);
        repeat (6) drive(1, 4'd2, 8'd99, 8'd1, 1, 4'd1, 8'd7, 8'd8, 0);
        drive(1, 4'd2, 8'd99, 8'd1, 1, 4'd1, 8'd7, 8'd8, 1);
        drive(1, 4'd2, 8'd99, 8'd1, 1, 4'd1, 8'd7, 8'd8, 1);
        repeat (3) drive(0, 4'd0, 8'd0, 8'd0, 0, 4'd0, 8'd0, 8'd0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            k  = $urandom_range(0, 7);
            o0 = (k < 3) ? 4'd1 : (k < 6) ? 4'd2 : (k == 6) ? 4'($urandom_range(0, MAXOP)) : 4'($urandom_range(MAXOP + 1, 15));
            k  = $urandom_range(0, 7);
            o1 = (k < 3) ? 4'd1 : (k < 6) ? 4'd2 : (k == 6) ? 4'($urandom_range(0, MAXOP)) : 4'($urandom_range(MAXOP + 1, 15));
            drive(1'($urandom_range(0, 1)), o0, 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), o1, 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20 && (busy || sb.size() > 0); i++)
            drive(0, 4'd0, 8'd0, 8'd0, 0, 4'd0, 8'd0, 8'd0, 1);
        check("scoreboard_drained", sb.size(), 0);

        // Latency-3 DUT: reset one cycle after accept drops the operation.
        @(negedge clk);
        q0_valid = 1; q0_op = 4'd1; q0_a = 8'd6; q0_b = 8'd9; r3_ready = 1;
        #1 check("d3_ready_accept", q0_ready, 1);
        @(negedge clk);
        q0_valid = 0;
        #1 check("d3_alu_a_issued", a3_a, 8'd6);
        @(negedge clk);
        reset3 = 1'b1;
        #1;
        check("d3_rst_resp_valid", r3_valid, 0);
        check("d3_rst_alu_fsel", a3_fsel, 0);
        check("d3_rst_alu_a", a3_a, 0);
        check("d3_rst_alu_b", a3_b, 0);
        check("d3_rst_result", r3_result, 0);
        check("d3_rst_err", r3_err, 0);
        @(negedge clk);
        reset3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check("d3_no_resp_after_reset", r3_valid, 0);
        end
        // Pointer back on requester 0 after reset.
        @(negedge clk);
        q0_valid = 1; q1_valid = 1;
        #1;
        check("d3_ptr_reset_r0", q0_ready, 1);
        check("d3_ptr_reset_r1", q1_ready, 0);
        @(negedge clk);
        q0_valid = 0; q1_valid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares the single clocked 8-bit ALU between two requesters (e.g. the instruction path and the address/debug path).
- Arbitrates between them and issues opcode and operands to the ALU.
- Waits the ALU's pipeline latency, captures the result and the 4-bit status register, and returns both with a valid/ready handshake.
- Sits between requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- ALU_LATENCY, 1: clock edges from ALU inputs registered to alu_out/alu_sreg valid; legal range >= 1.
- MAX_OP, 8: highest legal opcode; opcodes above it are rejected without using the ALU.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  4  function select
- req0_a  in  8  operand A
- req0_b  in  8  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0
- resp_valid  out  1  response available
- resp_ready  in  1  response consumed
- resp_id  out  1  requester that owns the response
- resp_result  out  8  ALU result
- resp_sreg  out  4  ALU status flags
- resp_err  out  1  opcode > MAX_OP
- alu_fsel  out  4  to ALU function_select_lines, registered
- alu_a  out  8  to ALU A, registered
- alu_b  out  8  to ALU B, registered
- alu_out  in  8  ALU result
- alu_sreg  in  4  ALU SREG

Behaviour:
- One clock domain; clk, asynchronous active-high reset.
- Reset values:
  - State IDLE; all outputs 0.
  - Round-robin pointer favours requester 0.
  - Latency counter 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Arbiter picks a granted requester among those with valid high.
  - reqN_ready = 1 combinationally for the granted requester only; the other ready stays 0.
  - At the accept edge (valid & ready):
    - resp_id <= grant.
    - If op <= MAX_OP: alu_fsel/alu_a/alu_b <= op/a/b, counter <= ALU_LATENCY, go WAIT.
    - Else: resp_err <= 1, resp_result <= 0, resp_sreg <= 0, go RESP; ALU inputs untouched.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter equals 1: resp_result <= alu_out, resp_sreg <= alu_sreg, resp_err <= 0, go RESP.
  - resp_valid therefore rises exactly ALU_LATENCY cycles after the accept edge.
- RESP:
  - resp_valid = 1; resp_* held stable until resp_ready.
  - Edge with resp_ready: go IDLE; resp_valid falls.
  - Both ready outputs stay 0 while not in IDLE, so at most one operation is ever in flight.
- Arbitration:
  - Round-robin: after a grant the pointer moves to the other requester.
  - If only one requester is valid, it wins regardless of the pointer.
- Back-to-back: resp_ready in RESP with a requester valid → the next accept happens in the following IDLE cycle (1 bubble).
- Requesters may drop valid before acceptance; no state change results.
- alu_fsel/a/b hold their last issued values outside WAIT.
- Reset mid-operation: in-flight operation is dropped, no response is produced, all outputs clear immediately.

Optional Feature:
- ALU_SCHED_FIXED_PRIO_EN defined: requester 0 always wins when both are valid; the pointer is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package alu_sched_pkg:
  - State enum (IDLE, WAIT, RESP).
  - Opcode width (4), data width (8), SREG width (4).
  - Default MAX_OP.
- Sub-module rr_arbiter2: 2-input request, one-hot grant, pointer update on an accept strobe. Fixed-priority mode selected by the macro.

Test Plan:
- Bench ALU stub returns out=A+B for op1 and A−B for op2 after ALU_LATENCY.
- Reset, then req0 op1 A=6 B=9 → req0_ready pulses one cycle; resp_valid rises 1 cycle after accept with resp_result=15, resp_id=0, resp_err=0.
- req0 and req1 valid in the same cycle (req0 op2 A=127 B=125, req1 op1 A=3 B=6), resp_ready tied 1:
  - Responses come in order id0 result 2, then id1 result 9.
  - With ALU_SCHED_FIXED_PRIO_EN and req0 held valid, req1 is never granted.
- req1 op 12 → accepted, no ALU input change, resp_err=1 and result 0 on the cycle after accept.
- resp_ready held low 5 cycles → resp_* stable and both ready outputs 0 throughout; release → back in IDLE next cycle.
- ALU_LATENCY=3, reset asserted 1 cycle after accept → all outputs 0 asynchronously; no response after reset release.
